aes_lockstep_miter: RTL

Run-time lockstep equivalence checker for the AES cipher output path. It compares a gold `text_out` stream against a gate-level `text_out` stream that may lag it by a bounded, variable number of valid beats. It applies a per-bit don't-care mask, counts compares and mismatches, and captures the first failing beat for debug. It sits beside `aes_cipher_top` in simulation and FPGA-prototype builds, and generalises the single-bit, purely combinational partition miter to wide, skewed, sequential streams.

---
 rtl/aes_lockstep_miter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes_lockstep_miter.sv
// Lockstep miter for the AES text_out path: gold beats are buffered and
// compared under a care mask against a lagging gate-level stream.
module aes_lockstep_miter #(
   parameter int unsigned WIDTH        = 128,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned WARMUP       = 2,
   parameter bit          STOP_ON_FAIL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             gold_valid,
   input  logic [WIDTH-1:0] gold_data,
   input  logic             gate_valid,
   input  logic [WIDTH-1:0] gate_data,
   input  logic [WIDTH-1:0] care_mask,
   output logic             mismatch,
   output logic             fail,
   output logic             overflow,
   output logic             underflow,
   output logic [CNT_W-1:0] cmp_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_diff,
   output logic [CNT_W-1:0] first_idx,
   output logic [1:0]       state
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      WARM  = 2'd0,
      CHECK = 2'd1,
      FAIL  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CMAX   = '1;
   localparam logic [CNT_W-1:0] WARM_N = CNT_W'(WARMUP);
   localparam logic [PW:0]      FULL   = (PW+1)'(DEPTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]      occ_q, occ_d;
   logic             mis_q, mis_d;
   logic             fail_q, fail_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [CNT_W-1:0] cmp_q, cmp_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [WIDTH-1:0] fdiff_q, fdiff_d;
   logic [CNT_W-1:0] fidx_q, fidx_d;

   logic             empty, full, active, bypass;
   logic             do_cmp, pop, push, ovf_ev, unf_ev, flag, err_ev;
   logic [WIDTH-1:0] gold_sel, diff;

   // Empty buffer with gold and gate together compares straight through.
   assign empty    = (occ_q == '0);
   assign full     = (occ_q == FULL);
   assign active   = (state_q != FAIL) && !clear;
   assign bypass   = gate_valid && empty && gold_valid;
   assign do_cmp   = active && gate_valid && (!empty || gold_valid);
   assign unf_ev   = active && gate_valid && empty && !gold_valid;
   assign pop      = do_cmp && !empty;
   assign ovf_ev   = active && gold_valid && full && !pop;
   assign push     = active && gold_valid && !bypass && !ovf_ev;
   assign gold_sel = bypass ? gold_data : mem_q[rd_q];
   assign diff     = (gold_sel ^ gate_data) & care_mask;
   assign flag     = do_cmp && (state_q == CHECK) && (diff != '0);
   assign err_ev   = flag || ovf_ev || unf_ev;

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      occ_d   = occ_q + (PW+1)'(push) - (PW+1)'(pop);
      mis_d   = flag;
      fail_d  = fail_q | err_ev;
      ovf_d   = ovf_q | ovf_ev;
      unf_d   = unf_q | unf_ev;
      cmp_d   = cmp_q;
      err_d   = err_q;
      fdiff_d = fdiff_q;
      fidx_d  = fidx_q;
      if (push) wr_d = wr_q + PW'(1);
      if (pop) rd_d = rd_q + PW'(1);
      if (do_cmp && cmp_q != CMAX) cmp_d = cmp_q + CNT_W'(1);
      if (flag && err_q != CMAX) err_d = err_q + CNT_W'(1);
      // err_q never wraps, so zero means nothing flagged yet.
      if (flag && err_q == '0) begin
         fdiff_d = diff;
         fidx_d  = cmp_q;
      end
      unique case (state_q)
         WARM: begin
            if (STOP_ON_FAIL && err_ev) state_d = FAIL;
            else if (cmp_d >= WARM_N) state_d = CHECK;
         end
         CHECK: begin
            if (STOP_ON_FAIL && err_ev) state_d = FAIL;
         end
         FAIL: state_d = FAIL;
         default: state_d = WARM;
      endcase
      if (clear) begin
         state_d = WARM;
         wr_d    = '0;
         rd_d    = '0;
         occ_d   = '0;
         mis_d   = 1'b0;
         fail_d  = 1'b0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
         cmp_d   = '0;
         err_d   = '0;
         fdiff_d = '0;
         fidx_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WARM;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
         mis_q   <= 1'b0;
         fail_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         cmp_q   <= '0;
         err_q   <= '0;
         fdiff_q <= '0;
         fidx_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
         mis_q   <= mis_d;
         fail_q  <= fail_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         cmp_q   <= cmp_d;
         err_q   <= err_d;
         fdiff_q <= fdiff_d;
         fidx_q  <= fidx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= gold_data;
   end

   assign mismatch   = mis_q;
   assign fail       = fail_q;
   assign overflow   = ovf_q;
   assign underflow  = unf_q;
   assign cmp_cnt    = cmp_q;
   assign err_cnt    = err_q;
   assign first_diff = fdiff_q;
   assign first_idx  = fidx_q;
   assign state      = state_q;

endmodule
